// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-side constants: default widths and the words returned for
// empty/faulting slots.
package cpu_fetch_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 6;

  // Value presented on instr_data when nothing valid sits at the FIFO head.
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
  // Value loaded for a fetch from an address beyond the populated image.
  localparam logic [31:0] FAULT_DATA = 32'h0000_0000;

endpackage

// File: rtl/rom_sync.sv
// Synchronous-read ROM, one cycle latency. The image is a constant table
// supplied as a packed parameter (word i at bits [i*DATA_W +: DATA_W]);
// every address at or beyond DEPTH reads as zero. Shared with the data side.
module rom_sync #(
  parameter int unsigned            DATA_W     = 32,
  parameter int unsigned            ADDR_W     = 6,
  parameter int unsigned            DEPTH      = 12,
  parameter logic [DEPTH*DATA_W-1:0] INIT_IMAGE = '0
) (
  input  logic              clka,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout
);

  localparam int unsigned WORDS = 2 ** ADDR_W;

  // Table spans the full address space so addr indexes it without range logic.
  logic [DATA_W-1:0] rom_w [WORDS];
  logic [DATA_W-1:0] dout_q;

  for (genvar i = 0; i < WORDS; i++) begin : g_rom
    if (i < DEPTH) begin : g_pop
      assign rom_w[i] = INIT_IMAGE[i*DATA_W +: DATA_W];
    end else begin : g_zero
      assign rom_w[i] = '0;
    end
  end

  // Registered read; output holds while en is low.
  always_ff @(posedge clka) begin
    if (en) begin
      dout_q <= rom_w[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/fetch_prefetch_rom.sv
// Instruction ROM with fetch front end: a word PC walks the image one read per
// cycle, results land in a small prefetch FIFO that drains to decode over
// valid/ready. A redirect reloads the PC and throws away everything fetched
// so far. Issue is credit-based (occupancy + read in flight - pop), so the
// FIFO can never overflow even with a read outstanding.
module fetch_prefetch_rom
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned             DATA_W     = DEF_DATA_W,
  parameter int unsigned             ADDR_W     = DEF_ADDR_W,
  parameter int unsigned             DEPTH      = 12,
  parameter int unsigned             FIFO_DEPTH = 4,
  parameter logic [DEPTH*DATA_W-1:0] INIT_IMAGE = '0,
  parameter logic [ADDR_W-1:0]       RESET_PC   = '0
) (
  input  logic                          clka,
  input  logic                          rsta,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_pc,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [DATA_W-1:0]             instr_data,
  output logic [ADDR_W-1:0]             instr_pc,
  output logic                          instr_fault,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]  FIFO_LIM = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  // Fetch PC and the read currently inside the ROM pipeline.
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              infl_valid_q, infl_valid_d;
  logic [ADDR_W-1:0] infl_pc_q;
  logic              infl_fault_q;

  // Prefetch FIFO: circular buffer, power-of-two depth so pointers wrap freely.
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_data_q  [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_pc_q    [FIFO_DEPTH];
  logic              mem_fault_q [FIFO_DEPTH];

  logic              fifo_nonempty;
  logic              pop;
  logic              push;
  logic              issue;
  logic              pc_fault;
  logic [CNT_W:0]    credit;
  logic [DATA_W-1:0] rom_dout;
  logic [DATA_W-1:0] push_data;

  rom_sync #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .INIT_IMAGE (INIT_IMAGE)
  ) u_rom (
    .clka (clka),
    .en   (issue),
    .addr (pc_q),
    .dout (rom_dout)
  );

  // Handshake, issue credit and push qualification.
  always_comb begin
    fifo_nonempty = (count_q != '0);
    pop           = fifo_nonempty && instr_ready;
    pc_fault      = ({1'b0, pc_q} >= DEPTH_L);
    credit        = {1'b0, count_q}
                  + (CNT_W + 1)'(infl_valid_q)
                  - (CNT_W + 1)'(pop);
    issue         = !redirect_valid && (credit < FIFO_LIM);
    // A redirect kills the read in flight: it never reaches the FIFO.
    push          = infl_valid_q && !redirect_valid;
    push_data     = infl_fault_q ? DATA_W'(FAULT_DATA) : rom_dout;
  end

  // Next-state for PC, in-flight flag, pointers and occupancy.
  always_comb begin
    pc_d         = pc_q;
    infl_valid_d = issue;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    if (redirect_valid) begin
      // A same-cycle pop has already been taken by the consumer; just flush.
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        pc_d = pc_q + ADDR_W'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state registers, synchronous reset.
  always_ff @(posedge clka) begin
    if (rsta) begin
      pc_q         <= RESET_PC;
      infl_valid_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      infl_valid_q <= infl_valid_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // Tag travelling alongside the ROM read; only meaningful while infl_valid_q.
  always_ff @(posedge clka) begin
    if (issue) begin
      infl_pc_q    <= pc_q;
      infl_fault_q <= pc_fault;
    end
  end

  // FIFO storage; stale slots are harmless because count gates the head.
  always_ff @(posedge clka) begin
    if (push) begin
      mem_data_q[wr_ptr_q]  <= push_data;
      mem_pc_q[wr_ptr_q]    <= infl_pc_q;
      mem_fault_q[wr_ptr_q] <= infl_fault_q;
    end
  end

  // Head outputs, forced to zero when the FIFO is empty.
  always_comb begin
    instr_valid = fifo_nonempty;
    instr_data  = DATA_W'(NOP_WORD);
    instr_pc    = '0;
    instr_fault = 1'b0;
    if (fifo_nonempty) begin
      instr_data  = mem_data_q[rd_ptr_q];
      instr_pc    = mem_pc_q[rd_ptr_q];
      instr_fault = mem_fault_q[rd_ptr_q];
    end
    fifo_count  = count_q;
  end

endmodule
